// File: rtl/apb_master_ctrl_pkg.sv
// Shared types for the APB master controller: FSM state encoding and a
// helper that sizes the optional ACCESS wait-state counter.
package apb_master_ctrl_pkg;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2,
        APB_DONE   = 2'd3
    } apb_state_e;

    // Bits needed to count from 0 up to and including max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Bundles the core-side request handshake and the APB pins of the master
// controller. The master modport is the controller's view; the slave modport
// is the view of whatever sits on the other side (core + APB slave).
interface apb_master_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic [DATA_W-1:0] req_rdata;
    logic              req_err;

    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  prdata, pready, pslverr,
        output req_ready, req_rdata, req_err,
        output paddr, pwdata, pwrite, psel, penable
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output prdata, pready, pslverr,
        input  req_ready, req_rdata, req_err,
        input  paddr, pwdata, pwrite, psel, penable
    );
endinterface

// File: rtl/apb_master_ctrl.sv
// APB master controller: turns the core's off-chip load/store request into an
// APB SETUP/ACCESS sequence and returns a one-cycle completion strobe with
// read data and error status. All outputs are registered.
//
// Optional build macro APB_TIMEOUT_EN: aborts an ACCESS phase after
// TIMEOUT_CYCLES wait states with req_err=1 (and req_rdata=0 for reads).
//
//   state      | meaning
//   APB_IDLE   | waiting for req_valid; request is latched on accept
//   APB_SETUP  | psel=1, penable=0 for one cycle
//   APB_ACCESS | psel=1, penable=1 until pready (or timeout)
//   APB_DONE   | bus released, req_ready pulses for this cycle
module apb_master_ctrl
    import apb_master_ctrl_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    apb_master_ctrl_if.master     bus
);

    apb_state_e        state_q,     state_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic              pwrite_q,    pwrite_d;
    logic              psel_q,      psel_d;
    logic              penable_q,   penable_d;
    logic              req_ready_q, req_ready_d;
    logic [DATA_W-1:0] req_rdata_q, req_rdata_d;
    logic              req_err_q,   req_err_d;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] to_cnt_inc;
`endif

    // Next-state and next-output computation; outputs are derived from the
    // state being entered so they appear registered in that state's cycle.
    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        req_ready_d = 1'b0;
        req_rdata_d = req_rdata_q;
        req_err_d   = req_err_q;
`ifdef APB_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        to_cnt_inc  = to_cnt_q + 1'b1;
`endif

        case (state_q)
            APB_IDLE: begin
                if (bus.req_valid) begin
                    paddr_d   = bus.req_addr;
                    pwdata_d  = bus.req_wdata;
                    pwrite_d  = bus.req_write;
                    req_err_d = 1'b0;
                    psel_d    = 1'b1;
                    state_d   = APB_SETUP;
`ifdef APB_TIMEOUT_EN
                    to_cnt_d  = '0;
`endif
                end
            end

            APB_SETUP: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
                state_d   = APB_ACCESS;
            end

            APB_ACCESS: begin
                if (bus.pready) begin
                    req_ready_d = 1'b1;
                    req_err_d   = bus.pslverr;
                    if (!pwrite_q) begin
                        req_rdata_d = bus.prdata;
                    end
                    state_d = APB_DONE;
                end else begin
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
                    to_cnt_d = to_cnt_inc;
                    // Abort once this wait cycle brings the count to the limit.
                    if (to_cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                        psel_d      = 1'b0;
                        penable_d   = 1'b0;
                        req_ready_d = 1'b1;
                        req_err_d   = 1'b1;
                        if (!pwrite_q) begin
                            req_rdata_d = '0;
                        end
                        state_d = APB_DONE;
                    end
`endif
                end
            end

            APB_DONE: begin
                state_d = APB_IDLE;
            end

            default: begin
                state_d = APB_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= APB_IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            req_ready_q <= 1'b0;
            req_rdata_q <= '0;
            req_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            req_ready_q <= req_ready_d;
            req_rdata_q <= req_rdata_d;
            req_err_q   <= req_err_d;
`ifdef APB_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.req_ready = req_ready_q;
    assign bus.req_rdata = req_rdata_q;
    assign bus.req_err   = req_err_q;

endmodule
